// File: rtl/sad_node_feeder_if.sv
// Pixel-pair stream in, per-lane difference/enable out to the adder tree.
interface sad_node_feeder_if #(
  parameter int unsigned NODE_NUM   = 8,
  parameter int unsigned PIX_WIDTH  = 8,
  parameter int unsigned NODE_WIDTH = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [PIX_WIDTH-1:0]  pix_l;
  logic [PIX_WIDTH-1:0]  pix_r;
  logic                  ena      [NODE_NUM];
  logic [NODE_WIDTH-1:0] add_node [NODE_NUM];
  logic                  acc_done;

  modport slave (
    input  in_valid, pix_l, pix_r, acc_done,
    output in_ready, ena, add_node
  );

  modport master (
    output in_valid, pix_l, pix_r, acc_done,
    input  in_ready, ena, add_node
  );
endinterface

// File: rtl/sad_node_feeder.sv
// Gathers NODE_NUM absolute pixel differences, fires them to an adder tree in one
// cycle, then waits (bounded by TIMEOUT) for the tree to report completion.
module sad_node_feeder #(
  parameter int unsigned NODE_NUM   = 8,
  parameter int unsigned PIX_WIDTH  = 8,
  parameter int unsigned NODE_WIDTH = 8,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  sad_node_feeder_if.slave   bus,
  output logic [15:0]        blk_cnt,
  output logic               err
);

  localparam int unsigned IdxW = $clog2(NODE_NUM);
  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

  if (NODE_WIDTH < PIX_WIDTH || NODE_NUM < 2 || (NODE_NUM & (NODE_NUM - 1)) != 0 ||
      TIMEOUT < 1) begin : g_bad_param
    $error("sad_node_feeder: illegal parameter combination");
  end

  typedef enum logic [1:0] {StFill, StFire, StWait} state_e;

  state_e                r_state, w_state_d;
  logic [IdxW-1:0]       r_idx, w_idx_d;
  logic [TmoW-1:0]       r_tmo, w_tmo_d;
  logic                  r_err, w_err_d;
  logic [15:0]           r_blk, w_blk_d;
  logic                  r_ena, w_ena_d;
  logic [NODE_WIDTH-1:0] r_lane [NODE_NUM];

  logic                  w_in_ready;
  logic                  w_hs;
  logic [PIX_WIDTH-1:0]  w_diff;

  assign w_in_ready = (r_state == StFill);
  // A handshake coinciding with flush is dropped.
  assign w_hs       = bus.in_valid & w_in_ready & ~flush;
  assign w_diff     = (bus.pix_l >= bus.pix_r) ? (bus.pix_l - bus.pix_r)
                                               : (bus.pix_r - bus.pix_l);

  always_comb begin
    w_state_d = r_state;
    w_idx_d   = r_idx;
    w_tmo_d   = r_tmo;
    w_err_d   = r_err;
    w_blk_d   = r_blk;
    if (flush) begin
      w_state_d = StFill;
      w_idx_d   = '0;
      w_tmo_d   = '0;
      w_err_d   = 1'b0;
    end else begin
      unique case (r_state)
        StFill: begin
          if (w_hs) begin
            if (r_idx == IdxW'(NODE_NUM - 1)) begin
              w_state_d = StFire;
              w_idx_d   = '0;
              w_blk_d   = r_blk + 16'd1;
            end else begin
              w_idx_d = r_idx + IdxW'(1);
            end
          end
        end
        StFire: begin
          w_state_d = StWait;
          w_tmo_d   = '0;
        end
        StWait: begin
          // acc_done beats a simultaneous timeout and leaves err alone.
          if (bus.acc_done) begin
            w_state_d = StFill;
            w_tmo_d   = '0;
          end else if (r_tmo == TmoW'(TIMEOUT - 1)) begin
            w_state_d = StFill;
            w_tmo_d   = '0;
            w_err_d   = 1'b1;
          end else begin
            w_tmo_d = r_tmo + TmoW'(1);
          end
        end
        default: w_state_d = StFill;
      endcase
    end
    w_ena_d = (w_state_d == StFire);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StFill;
      r_idx   <= '0;
      r_tmo   <= '0;
      r_err   <= 1'b0;
      r_blk   <= '0;
      r_ena   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_idx   <= w_idx_d;
      r_tmo   <= w_tmo_d;
      r_err   <= w_err_d;
      r_blk   <= w_blk_d;
      r_ena   <= w_ena_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NODE_NUM; k++) r_lane[k] <= '0;
    end else if (flush) begin
      for (int k = 0; k < NODE_NUM; k++) r_lane[k] <= '0;
    end else if (w_hs) begin
      r_lane[r_idx] <= NODE_WIDTH'(w_diff);
    end
  end

  for (genvar g = 0; g < NODE_NUM; g++) begin : g_lane
    assign bus.ena[g]      = r_ena;
    assign bus.add_node[g] = r_lane[g];
  end

  assign bus.in_ready = w_in_ready;
  assign blk_cnt      = r_blk;
  assign err          = r_err;

endmodule

// File: tb/tb_sad_node_feeder.sv
// Directed bench for sad_node_feeder with a 3-stage adder-tree model and a
// scoreboard of expected lane vectors and window sums.
module tb_sad_node_feeder;
  localparam int unsigned NN = 8;
  localparam int unsigned PW = 8;
  localparam int unsigned NW = 8;
  localparam int unsigned TO = 16;
  localparam int unsigned SW = NW + 3;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [15:0] blk_cnt;
  logic        err;

  sad_node_feeder_if #(.NODE_NUM(NN), .PIX_WIDTH(PW), .NODE_WIDTH(NW)) bus ();

  sad_node_feeder #(
    .NODE_NUM  (NN),
    .PIX_WIDTH (PW),
    .NODE_WIDTH(NW),
    .TIMEOUT   (TO)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (flush),
    .bus    (bus),
    .blk_cnt(blk_cnt),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Adder-tree model: three pipeline stages from the ena pulse to acc_done.
  logic          all_ena, any_ena;
  logic [SW-1:0] lane_sum;
  logic [NN*NW-1:0] got_lanes;
  logic [2:0]    t_v;
  logic [SW-1:0] t_s [3];
  logic          tree_en, done_force;
  logic [SW-1:0] add_res;

  always_comb begin
    all_ena   = 1'b1;
    any_ena   = 1'b0;
    lane_sum  = '0;
    got_lanes = '0;
    for (int i = 0; i < NN; i++) begin
      all_ena = all_ena & bus.ena[i];
      any_ena = any_ena | bus.ena[i];
      lane_sum = lane_sum + SW'(bus.add_node[i]);
      got_lanes[i*NW +: NW] = bus.add_node[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_v <= '0;
      for (int i = 0; i < 3; i++) t_s[i] <= '0;
    end else begin
      t_v    <= {t_v[1:0], all_ena};
      t_s[0] <= lane_sum;
      t_s[1] <= t_s[0];
      t_s[2] <= t_s[1];
    end
  end

  assign add_res      = t_s[2];
  assign bus.acc_done = (tree_en & t_v[2]) | done_force;

  int n_tests = 0;
  int n_fail  = 0;

  logic [NN*NW-1:0] win_q [$];
  logic [SW-1:0]    sum_q [$];
  logic [NN*NW-1:0] cur;
  logic [SW-1:0]    cur_sum;
  int               k;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NW-1:0] absd(input logic [PW-1:0] a, input logic [PW-1:0] b);
    return (a >= b) ? NW'(a - b) : NW'(b - a);
  endfunction

  task automatic model_clear();
    k       = 0;
    cur     = '0;
    cur_sum = '0;
  endtask

  // Waits (bounded) for in_ready, then presents one pair for one cycle.
  task automatic send(input logic [PW-1:0] l, input logic [PW-1:0] r);
    int w = 0;
    while (!bus.in_ready && w < 50) begin
      bus.in_valid = 1'b0;
      @(negedge clk);
      w++;
    end
    if (!bus.in_ready) check("send_ready_wait", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.pix_l    = l;
    bus.pix_r    = r;
    cur[k*NW +: NW] = absd(l, r);
    cur_sum = cur_sum + SW'(absd(l, r));
    k++;
    if (k == NN) begin
      win_q.push_back(cur);
      sum_q.push_back(cur_sum);
      model_clear();
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done(input string tag, input int exp_cyc);
    int cyc = 0;
    while (!bus.acc_done && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check(tag, 64'(cyc), 64'(exp_cyc));
    @(negedge clk);
    check({tag, "_ready"}, 64'(bus.in_ready), 64'd1);
  endtask

  // Scoreboard side: every fire and every tree result pops an expectation.
  always @(negedge clk) begin
    if (any_ena) begin
      check("fire_all_ena", 64'(all_ena), 64'd1);
      check("fire_expected", 64'(win_q.size() != 0), 64'd1);
      if (win_q.size() != 0) check("fire_lanes", 64'(got_lanes), 64'(win_q.pop_front()));
    end
    if (t_v[2]) begin
      check("tree_expected", 64'(sum_q.size() != 0), 64'd1);
      if (sum_q.size() != 0) check("tree_sum", 64'(add_res), 64'(sum_q.pop_front()));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    flush        = 1'b0;
    tree_en      = 1'b1;
    done_force   = 1'b0;
    bus.in_valid = 1'b0;
    bus.pix_l    = '0;
    bus.pix_r    = '0;
    model_clear();

    // Reset values, then a reset pulse in the middle of a window.
    repeat (2) @(negedge clk);
    check("rst_ena", 64'(any_ena), 64'd0);
    check("rst_lanes", 64'(got_lanes), 64'd0);
    check("rst_blk", 64'(blk_cnt), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 64'(bus.in_ready), 64'd1);
    for (int i = 0; i < 3; i++) send(PW'(i + 40), PW'(3));
    rst_n = 1'b0;
    #1;
    check("midrst_lanes", 64'(got_lanes), 64'd0);
    check("midrst_blk", 64'(blk_cnt), 64'd0);
    model_clear();
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_ready", 64'(bus.in_ready), 64'd1);
    idle(3);

    // Full back-to-back window.
    for (int i = 0; i < 8; i++) send(PW'(10 * i + 20), PW'(10 * i));
    bus.in_valid = 1'b0;
    check("full_blk", 64'(blk_cnt), 64'd1);
    check("full_fire_ready", 64'(bus.in_ready), 64'd0);
    for (int i = 0; i < 8; i++) check("full_lane", 64'(bus.add_node[i]), 64'd20);
    begin
      int cyc = 0;
      while (!bus.acc_done && cyc < 10) begin
        @(negedge clk);
        cyc++;
      end
      check("full_done_lat", 64'(cyc), 64'd3);
      check("full_add_res", 64'(add_res), 64'd160);
      @(negedge clk);
      check("full_ready_after", 64'(bus.in_ready), 64'd1);
      check("full_hold", 64'(bus.add_node[3]), 64'd20);
    end

    // Abs direction and extremes.
    send(8'd5, 8'd250);
    send(8'd255, 8'd0);
    send(8'd7, 8'd7);
    send(8'd1, 8'd2);
    send(8'd200, 8'd100);
    send(8'd0, 8'd0);
    send(8'd9, 8'd3);
    send(8'd128, 8'd127);
    bus.in_valid = 1'b0;
    check("abs_lane0", 64'(bus.add_node[0]), 64'd245);
    check("abs_lane1", 64'(bus.add_node[1]), 64'd255);
    check("abs_lane2", 64'(bus.add_node[2]), 64'd0);
    check("abs_blk", 64'(blk_cnt), 64'd2);
    wait_done("abs_done", 3);

    // Stalled stream; a stray acc_done while filling must be ignored.
    for (int i = 0; i < 8; i++) begin
      send(PW'(i * 30), PW'(7));
      if (i < 7) begin
        if (i == 3) begin
          bus.in_valid = 1'b0;
          done_force   = 1'b1;
          @(negedge clk);
          done_force   = 1'b0;
          idle(1);
          check("stall_ready", 64'(bus.in_ready), 64'd1);
        end else begin
          idle(2);
        end
      end
      if (i == 6) check("stall_nofire", 64'(blk_cnt), 64'd2);
    end
    bus.in_valid = 1'b0;
    check("stall_blk", 64'(blk_cnt), 64'd3);
    wait_done("stall_done", 3);

    // Flush after five pairs, with a pair offered in the flush cycle.
    for (int i = 0; i < 5; i++) send(PW'(50), PW'(i));
    flush        = 1'b1;
    bus.in_valid = 1'b1;
    bus.pix_l    = 8'd99;
    bus.pix_r    = 8'd0;
    @(negedge clk);
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    model_clear();
    check("flush_lanes", 64'(got_lanes), 64'd0);
    check("flush_ena", 64'(any_ena), 64'd0);
    check("flush_blk", 64'(blk_cnt), 64'd3);
    check("flush_ready", 64'(bus.in_ready), 64'd1);
    idle(2);
    check("flush_nofire", 64'(blk_cnt), 64'd3);
    for (int i = 0; i < 8; i++) send(PW'(i + 1), PW'(2 * i + 40));
    bus.in_valid = 1'b0;
    check("flush_refill_blk", 64'(blk_cnt), 64'd4);
    wait_done("flush_done", 3);

    // Timeout with the tree disconnected.
    tree_en = 1'b0;
    for (int i = 0; i < 8; i++) send(PW'(3 * i), PW'(100));
    bus.in_valid = 1'b0;
    check("tmo_blk", 64'(blk_cnt), 64'd5);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 1 || i == 16) begin
        check("tmo_wait_err", 64'(err), 64'd0);
        check("tmo_wait_ready", 64'(bus.in_ready), 64'd0);
      end
    end
    @(negedge clk);
    check("tmo_err", 64'(err), 64'd1);
    check("tmo_ready", 64'(bus.in_ready), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("tmo_flush_err", 64'(err), 64'd0);
    check("tmo_flush_blk", 64'(blk_cnt), 64'd5);

    // acc_done on the timeout cycle wins.
    for (int i = 0; i < 8; i++) send(PW'(i), PW'(255 - i));
    bus.in_valid = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 16) done_force = 1'b1;
    end
    @(negedge clk);
    done_force = 1'b0;
    check("tie_err", 64'(err), 64'd0);
    check("tie_ready", 64'(bus.in_ready), 64'd1);
    check("tie_blk", 64'(blk_cnt), 64'd6);

    tree_en = 1'b1;
    idle(6);
    check("sb_win_empty", 64'(win_q.size()), 64'd0);
    check("sb_sum_empty", 64'(sum_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
